// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op encoding, datapath widths and the
// legal-op check used by the response decoder.
package alu_arbiter_pkg;

    localparam int ALU_OP_W = 4;
    localparam int DATA_W   = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b0001;
    localparam alu_op_t ALU_AND  = 4'b0010;
    localparam alu_op_t ALU_OR   = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SLT  = 4'b0101;
    localparam alu_op_t ALU_SLTU = 4'b0110;
    localparam alu_op_t ALU_SLL  = 4'b0111;
    localparam alu_op_t ALU_SRL  = 4'b1000;
    localparam alu_op_t ALU_SRA  = 4'b1001;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              illegal;
    } rsp_t;

    function automatic logic is_legal_alu_op(input alu_op_t op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the request channel, ALU drive, response slot and debug counters
// of the ALU arbiter; slave is the arbiter side, master the environment.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*ALU_OP_W-1:0] req_alu_control;
    logic [NUM_REQ*DATA_W-1:0]   req_src1;
    logic [NUM_REQ*DATA_W-1:0]   req_src2;

    alu_op_t                     alu_control;
    logic [DATA_W-1:0]           alu_src1;
    logic [DATA_W-1:0]           alu_src2;
    logic [DATA_W-1:0]           alu_result;
    logic                        alu_zero;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [DATA_W-1:0]           rsp_result;
    logic                        rsp_zero;
    logic                        rsp_illegal;

    logic [NUM_REQ*CNT_W-1:0]    grant_cnt;

    modport slave (
        input  req_valid, req_alu_control, req_src1, req_src2,
        input  alu_result, alu_zero, rsp_ready,
        output req_ready, alu_control, alu_src1, alu_src2,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, grant_cnt
    );

    modport master (
        output req_valid, req_alu_control, req_src1, req_src2,
        output alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_control, alu_src1, alu_src2,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, grant_cnt
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from last+1 upward with wrap and returns a
// one-hot grant, its binary index and whether any grant was made.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    // First valid requester after the last winner; the first hit masks the rest.
    always_comb begin
        logic [ID_W-1:0] cand;
        logic            hit;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand        = ID_W'((int'(last) + k) % NUM_REQ);
            hit         = en && !found && req[cand];
            grant[cand] = grant[cand] | hit;
            idx         = hit ? cand : idx;
            found       = found | hit;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, combinational
// operand mux, one registered response slot and saturating grant counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    logic                             accept_s;
    logic [NUM_REQ-1:0]               grant_s;
    logic [ID_W-1:0]                  grant_idx_s;
    logic                             grant_any_s;
    alu_op_t                          op_s;
    logic [DATA_W-1:0]                src1_s;
    logic [DATA_W-1:0]                src2_s;
    logic                             illegal_s;
    rsp_t                             rsp_next_s;

    logic [ID_W-1:0]                  last_r;
    logic                             rsp_valid_r;
    logic [ID_W-1:0]                  rsp_id_r;
    rsp_t                             rsp_r;
    logic [NUM_REQ-1:0][CNT_W-1:0]    cnt_r;

    // The slot may refill in the same cycle the consumer drains it.
    assign accept_s = !rsp_valid_r || bus.rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (bus.req_valid),
        .en    (accept_s),
        .last  (last_r),
        .grant (grant_s),
        .idx   (grant_idx_s),
        .found (grant_any_s)
    );

    assign bus.req_ready = grant_s;

    // Operand mux: granted requester's op and sources, otherwise all zero.
    always_comb begin
        if (grant_any_s) begin
            op_s   = bus.req_alu_control[{grant_idx_s, 2'b00} +: ALU_OP_W];
            src1_s = bus.req_src1[{grant_idx_s, 5'b00000} +: DATA_W];
            src2_s = bus.req_src2[{grant_idx_s, 5'b00000} +: DATA_W];
        end else begin
            op_s   = ALU_ADD;
            src1_s = {DATA_W{1'b0}};
            src2_s = {DATA_W{1'b0}};
        end
    end

    assign bus.alu_control = op_s;
    assign bus.alu_src1    = src1_s;
    assign bus.alu_src2    = src2_s;

    assign illegal_s = !is_legal_alu_op(op_s);

    // Illegal ops are still consumed but report a forced zero result.
    always_comb begin
        if (illegal_s) begin
            rsp_next_s.result  = {DATA_W{1'b0}};
            rsp_next_s.zero    = 1'b1;
            rsp_next_s.illegal = 1'b1;
        end else begin
            rsp_next_s.result  = bus.alu_result;
            rsp_next_s.zero    = bus.alu_zero;
            rsp_next_s.illegal = 1'b0;
        end
    end

    // Response slot and priority pointer; both move only on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_r       <= '0;
            last_r      <= LAST_RST;
        end else if (grant_any_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= grant_idx_s;
            rsp_r       <= rsp_next_s;
            last_r      <= grant_idx_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Per-requester accepted-request counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_id      = rsp_id_r;
    assign bus.rsp_result  = rsp_r.result;
    assign bus.rsp_zero    = rsp_r.zero;
    assign bus.rsp_illegal = rsp_r.illegal;
    assign bus.grant_cnt   = cnt_r;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between NUM_REQ requesters, e.g. the main execute path and a multi-cycle address/compare sequencer.
- Round-robin arbitration on a valid/ready request channel; the selected operands drive the ALU combinationally.
- The ALU result is captured into a single registered response slot, returned with the requester id.
- Keeps per-requester saturating grant counters for performance debug.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
ID_W, $clog2(NUM_REQ), width of requester id
CNT_W, 16, width of each grant counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted this cycle, one-hot or zero
req_alu_control  in  NUM_REQ*4  ALU op per requester (slice i = bits 4i+3:4i)
req_src1  in  NUM_REQ*32  operand 1 per requester
req_src2  in  NUM_REQ*32  operand 2 per requester
alu_control  out  4  to ALU
alu_src1  out  32  to ALU
alu_src2  out  32  to ALU
alu_result  in  32  from ALU
alu_zero  in  1  from ALU
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes response
rsp_id  out  ID_W  requester that issued the op
rsp_result  out  32  captured result
rsp_zero  out  1  captured zero flag
rsp_illegal  out  1  op code was not a defined ALU code
grant_cnt  out  NUM_REQ*CNT_W  saturating accepted-request count per requester

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, all grant_cnt=0, last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
- accept = !rsp_valid || rsp_ready. The slot can refill in the same cycle it drains.
- Grant (combinational):
  - When accept=1 and any req_valid is set, grant goes to the first valid requester found from (last+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 for the granted requester only.
  - req_ready is 0 for all requesters when accept=0 or no requester is valid.
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- ALU drive:
  - When a grant is made, alu_control/alu_src1/alu_src2 come from the granted requester.
  - Otherwise they are driven to 4'b0000 / 0 / 0 (constant, no latch).
- Handshake at a clock edge: req_valid[g] && req_ready[g]. On handshake:
  - rsp_valid<=1, rsp_id<=g, rsp_result<=alu_result, rsp_zero<=alu_zero.
  - last<=g.
  - grant_cnt[g]<=grant_cnt[g]+1, saturating at all-ones.
- Legal ALU codes: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000, 1001.
- Codes 1010..1111 are illegal. An illegal op is still granted and consumed, and the response slot captures rsp_result=0, rsp_zero=1, rsp_illegal=1. For legal ops rsp_illegal=0.
- Latency: 1 cycle from handshake to rsp_valid. Throughput: 1 op/cycle while rsp_ready=1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable, req_ready=0, and the pointer and counters are frozen.
- On rsp_ready=1 with no new handshake, rsp_valid<=0. Data outputs keep their last values (don't-care).
- Pointer changes only on a handshake. Idle cycles do not rotate priority.
- A single valid requester is granted every accepting cycle, with no bubble.
- Reset mid-operation: a pending response is discarded with no replay, and the pointer returns to NUM_REQ-1.

Decomposition:
- Shared package holds:
  - the 4-bit ALU op typedef;
  - named constants for the ten ALU codes;
  - an is_legal_alu_op function, shared with the decoder.
- One sub-module, rr_arbiter: parameterised NUM_REQ round-robin, taking req vector, enable and last pointer, and returning a one-hot grant plus binary index.
- Response slot, counters and ALU mux stay in alu_arbiter.

Test Plan:
- Single requester, req0: op 0000, src1=5, src2=7, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, grant_cnt[0]=1.
- Both requesters valid continuously, rsp_ready=1 → grant sequence 0,1,0,1. req1 op 0001 with 3,3 → rsp_result=0, rsp_zero=1. req0 op 1001 with 0x80000000 and 4 → 0xF8000000.
- Backpressure: response pending, rsp_ready=0 for 3 cycles while both requesters are valid → req_ready=0, rsp_* stable, counters unchanged. Then rsp_ready=1 → new grant issued in that same cycle.
- Illegal op 1100 from req1 → req_ready[1]=1, response rsp_id=1, rsp_illegal=1, rsp_result=0, rsp_zero=1. A following legal 0101 with src1=-1, src2=1 → rsp_result=1, rsp_illegal=0.
- Counter saturation with CNT_W=4: 20 grants to req0 → grant_cnt[0]=15.
- Async reset asserted mid-cycle while rsp_valid=1 → rsp_valid=0 immediately, counters=0. After release, with both valid → req0 granted first.
